// File: rtl/dm_port_arbiter_pkg.sv
// Shared encodings and default parameters for the data-memory port arbiter.
package dm_port_arbiter_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 16;
  localparam int STARVE_MAX_DEF = 4;
  localparam int STARVE_CNT_W   = 4;   // holds STARVE_MAX up to 15

  typedef enum logic {
    MODE_NORM = 1'b0,
    MODE_HALT = 1'b1
  } mode_e;

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// Saturating host-starvation counter with clear; at_max flags a forced host grant.
module dm_arb_starve_cnt
  import dm_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  input  logic                    clr,
  output logic [STARVE_CNT_W-1:0] cnt,
  output logic                    at_max
);

  localparam logic [STARVE_CNT_W-1:0] MAX_VAL = STARVE_CNT_W'(STARVE_MAX);

  assign at_max = (cnt == MAX_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU DM stage and a host requester.
// Optional DM_ARB_STATS_EN adds saturating grant/stall statistics counters.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_re,
  input  logic                    cpu_we,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_stall,
  input  logic                    cpu_hlt,
  input  logic                    host_req,
  input  logic                    host_we,
  input  logic [ADDR_W-1:0]       host_addr,
  input  logic [DATA_W-1:0]       host_wdata,
  output logic                    host_gnt,
  output logic                    host_rvalid,
  output logic [DATA_W-1:0]       host_rdata,
  output logic                    mem_re,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
`ifdef DM_ARB_STATS_EN
  input  logic                    stat_clr,
  output logic [15:0]             stat_host_gnts,
  output logic [15:0]             stat_cpu_stalls,
`endif
  output logic                    dbg_mode,
  output logic [STARVE_CNT_W-1:0] dbg_starve_cnt
);

  // Host handshake: host_req and its payload stay stable until host_gnt, which is
  // combinational, so a request completes in the cycle host_gnt is high.
  mode_e mode_q, mode_d;
  logic  cpu_req, at_max, starve_inc, starve_clr;

  assign cpu_req = cpu_re | cpu_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= MODE_NORM;
    else        mode_q <= mode_d;
  end

  // HALT is sticky until reset.
  always_comb begin
    mode_d = mode_q;
    if (mode_q == MODE_NORM && cpu_hlt) mode_d = MODE_HALT;
  end

  assign host_gnt  = host_req & (~cpu_req | at_max | (mode_q == MODE_HALT) | cpu_hlt);
  assign cpu_stall = cpu_req & host_gnt;

  assign starve_inc = host_req & ~host_gnt;
  assign starve_clr = host_gnt | ~host_req;

  dm_arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .cnt    (dbg_starve_cnt),
    .at_max (at_max)
  );

  // A simultaneous cpu_re/cpu_we is treated as a write.
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (host_gnt) begin
      mem_re    = ~host_we;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (cpu_req) begin
      mem_re    = cpu_re & ~cpu_we;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) host_rvalid <= 1'b0;
    else        host_rvalid <= host_gnt & ~host_we;
  end

  assign host_rdata = mem_rdata;
  assign cpu_rdata  = mem_rdata;
  assign dbg_mode   = mode_q;

`ifdef DM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_host_gnts  <= '0;
      stat_cpu_stalls <= '0;
    end else if (stat_clr) begin
      stat_host_gnts  <= '0;
      stat_cpu_stalls <= '0;
    end else begin
      if (host_gnt && stat_host_gnts != 16'hFFFF)   stat_host_gnts  <= stat_host_gnts + 1'b1;
      if (cpu_stall && stat_cpu_stalls != 16'hFFFF) stat_cpu_stalls <= stat_cpu_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural single-port memory.
// Covers DM_ARB_STATS_EN when the macro is defined.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_re, cpu_we, cpu_hlt, host_req, host_we;
  logic [15:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic [15:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, host_gnt, host_rvalid, mem_re, mem_we, dbg_mode;
  logic [3:0]  dbg_starve_cnt;
`ifdef DM_ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_host_gnts, stat_cpu_stalls;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dm_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_hlt(cpu_hlt),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef DM_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_host_gnts(stat_host_gnts), .stat_cpu_stalls(stat_cpu_stalls),
`endif
    .dbg_mode(dbg_mode), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // Behavioural memory: write and registered read on the clock edge.
  logic [15:0] mem [0:255];
  logic [15:0] mem_rd_q;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h10] = 16'hBEEF;
    mem_rd_q   = 16'h0;
  end
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_re) mem_rd_q <= mem[mem_addr[7:0]];
  end
  assign mem_rdata = mem_rd_q;

  typedef struct {
    logic        cpu_re, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        host_req, host_we;
    logic [15:0] host_addr, host_wdata;
    logic        e_gnt, e_stall, e_re, e_we;
    logic [15:0] e_addr, e_wdata;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_hlt = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
`ifdef DM_ARB_STATS_EN
    stat_clr = 0;
`endif
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
  endtask

  task automatic set_cpu(input logic re, input logic we, input logic [15:0] a, input logic [15:0] d);
    cpu_re = re; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_host(input logic rq, input logic we, input logic [15:0] a, input logic [15:0] d);
    host_req = rq; host_we = we; host_addr = a; host_wdata = d;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #3;
    rst_n = 1;
  endtask

  task automatic check_port(input string tag, input logic gnt, input logic stall,
                            input logic re, input logic we, input logic [15:0] a);
    check({tag, ".host_gnt"},  host_gnt,  gnt);
    check({tag, ".cpu_stall"}, cpu_stall, stall);
    check({tag, ".mem_re"},    mem_re,    re);
    check({tag, ".mem_we"},    mem_we,    we);
    check({tag, ".mem_addr"},  mem_addr,  a);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    #12;
    check("rst.host_rvalid", host_rvalid, 1'b0);
    check("rst.mode", dbg_mode, 1'b0);
    check("rst.cnt", dbg_starve_cnt, 4'd0);
    check_port("rst", 0, 0, 0, 0, 16'h0);
    check("rst.mem_wdata", mem_wdata, 16'h0);
    rst_n = 1;

    // {cpu_re,we,addr,wdata, host_req,we,addr,wdata, exp gnt,stall,re,we,addr,wdata}
    vecs[0] = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000,16'h0000};
    vecs[1] = '{1,0,16'h0040,16'h0000, 0,0,16'h0000,16'h0000, 0,0,1,0,16'h0040,16'h0000};
    vecs[2] = '{0,1,16'h0041,16'hAAAA, 0,0,16'h0000,16'h0000, 0,0,0,1,16'h0041,16'hAAAA};
    vecs[3] = '{0,0,16'h0000,16'h0000, 1,0,16'h0010,16'h0000, 1,0,1,0,16'h0010,16'h0000};
    vecs[4] = '{0,0,16'h0000,16'h0000, 1,1,16'h0011,16'h7777, 1,0,0,1,16'h0011,16'h7777};
    vecs[5] = '{1,1,16'h0042,16'h1111, 0,0,16'h0000,16'h0000, 0,0,0,1,16'h0042,16'h1111};
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      set_cpu(vecs[i].cpu_re, vecs[i].cpu_we, vecs[i].cpu_addr, vecs[i].cpu_wdata);
      set_host(vecs[i].host_req, vecs[i].host_we, vecs[i].host_addr, vecs[i].host_wdata);
      mid_cycle();
      check_port($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_stall,
                 vecs[i].e_re, vecs[i].e_we, vecs[i].e_addr);
      check($sformatf("vec%0d.mem_wdata", i), mem_wdata, vecs[i].e_wdata);
    end
    next_cycle(); idle_inputs();

    // Host read alone: same-cycle grant, data one cycle later.
    next_cycle(); set_host(1, 0, 16'h0010, 0);
    mid_cycle(); check_port("hrd", 1, 0, 1, 0, 16'h0010);
    next_cycle(); idle_inputs();
    mid_cycle();
    check("hrd.rvalid", host_rvalid, 1'b1);
    check("hrd.rdata", host_rdata, 16'hBEEF);
    check("hrd.cpu_stall", cpu_stall, 1'b0);
    next_cycle();
    mid_cycle(); check("hrd.rvalid_drop", host_rvalid, 1'b0);

    // Contention: CPU loads each cycle, host write forced through on the 5th.
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      set_cpu(1, 0, 16'h0050, 0);
      if (c <= 5) set_host(1, 1, 16'h0020, 16'h1234);
      else        set_host(0, 0, 0, 0);
      mid_cycle();
      if (c == 5) check_port($sformatf("cont%0d", c), 1, 1, 0, 1, 16'h0020);
      else        check_port($sformatf("cont%0d", c), 0, 0, 1, 0, 16'h0050);
      check($sformatf("cont%0d.cnt", c), dbg_starve_cnt, (c <= 5) ? 4'(c - 1) : 4'd0);
    end
    next_cycle(); idle_inputs(); set_host(1, 0, 16'h0020, 0);
    mid_cycle(); check("cont.rd_gnt", host_gnt, 1'b1);
    next_cycle(); idle_inputs();
    mid_cycle(); check("cont.mem20", host_rdata, 16'h1234);

    // Priority: CPU store wins at counter 0, host read follows and sees the store.
    next_cycle(); set_cpu(0, 1, 16'h0030, 16'h5555); set_host(1, 0, 16'h0030, 0);
    mid_cycle(); check_port("prio1", 0, 0, 0, 1, 16'h0030);
    next_cycle(); set_cpu(0, 0, 0, 0);
    mid_cycle(); check_port("prio2", 1, 0, 1, 0, 16'h0030);
    next_cycle(); idle_inputs();
    mid_cycle();
    check("prio.rvalid", host_rvalid, 1'b1);
    check("prio.rdata", host_rdata, 16'h5555);

    // Halt: host owns the port from the cpu_hlt cycle onward, mode sticks.
    next_cycle(); set_cpu(1, 0, 16'h0060, 0); set_host(1, 0, 16'h0010, 0); cpu_hlt = 1;
    mid_cycle();
    check_port("hlt0", 1, 1, 1, 0, 16'h0010);
    check("hlt0.mode", dbg_mode, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      next_cycle(); cpu_hlt = 0;
      mid_cycle();
      check_port($sformatf("hlt%0d", c), 1, 1, 1, 0, 16'h0010);
      check($sformatf("hlt%0d.mode", c), dbg_mode, 1'b1);
    end
    next_cycle(); set_host(0, 0, 0, 0);
    mid_cycle(); check_port("hlt_cpu_only", 0, 0, 1, 0, 16'h0060);

    // Reset in the cycle after a host read grant.
    next_cycle(); idle_inputs(); set_host(1, 0, 16'h0010, 0);
    mid_cycle(); check("rstrd.gnt", host_gnt, 1'b1);
    next_cycle(); idle_inputs();
    check("rstrd.rvalid_pre", host_rvalid, 1'b1);
    rst_n = 0;
    #1;
    check("rstrd.rvalid", host_rvalid, 1'b0);
    check("rstrd.mode", dbg_mode, 1'b0);
    check("rstrd.cnt", dbg_starve_cnt, 4'd0);
    rst_n = 1;

    // Reset clears a partly built starvation count.
    for (int c = 0; c < 3; c++) begin
      next_cycle(); set_cpu(1, 0, 16'h0070, 0); set_host(1, 1, 16'h0021, 16'h0BAD);
    end
    next_cycle();
    check("rstcnt.pre", dbg_starve_cnt, 4'd3);
    idle_inputs();
    do_reset();
    check("rstcnt.cnt", dbg_starve_cnt, 4'd0);

`ifdef DM_ARB_STATS_EN
    check("stat.rst_gnts", stat_host_gnts, 16'd0);
    check("stat.rst_stalls", stat_cpu_stalls, 16'd0);
    for (int c = 0; c < 15; c++) begin
      next_cycle(); set_cpu(1, 0, 16'h0070, 0); set_host(1, 0, 16'h0012, 0);
    end
    next_cycle(); idle_inputs();
    check("stat.gnts", stat_host_gnts, 16'd3);
    check("stat.stalls", stat_cpu_stalls, 16'd3);
    set_host(1, 0, 16'h0012, 0); stat_clr = 1;
    next_cycle(); idle_inputs();
    check("stat.clr_gnts", stat_host_gnts, 16'd0);
    check("stat.clr_stalls", stat_cpu_stalls, 16'd0);
`endif

    next_cycle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-port synchronous data memory between the pipeline's data-memory stage (loads and stores) and an external host/debug requester.
- The host requester serves memory dumps after HLT, test preload, and future DMA.
- By default the CPU has priority. A starvation counter guarantees the host a slot.
- Once the pipeline halts, the host owns the port permanently.

Parameters:
- ADDR_W, 16, address width for both requesters and the memory.
- DATA_W, 16, data width.
- STARVE_MAX, 4, number of consecutive denied host cycles after which the host is force-granted (range 1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_re  in  1  pipeline load request (DM stage)
- cpu_we  in  1  pipeline store request (DM stage)
- cpu_addr  in  ADDR_W  pipeline address
- cpu_wdata  in  DATA_W  pipeline store data
- cpu_rdata  out  DATA_W  load data, valid the cycle after an ungranted-stall-free cpu_re
- cpu_stall  out  1  CPU access not performed this cycle; hold the pipeline and the request
- cpu_hlt  in  1  pipelined halt (sticky once set)
- host_req  in  1  host access request
- host_we  in  1  host write (1) / read (0)
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host access performed this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, one cycle after mem_re

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset state: mode=NORM, starve_cnt=0, host_rvalid=0.
- Combinational outputs at reset: mem_re/mem_we/host_gnt/cpu_stall are 0 when there is no request; mem_addr/mem_wdata are 0 when idle.
- Requests: cpu_req = cpu_re|cpu_we.
  - cpu_re&cpu_we together is illegal; the write is performed and the read data is undefined.
  - host_req, host_we, host_addr and host_wdata are held stable until host_gnt (valid/grant handshake, grant in the same cycle).
- Mode FSM (2 states):
  - NORM -> HALT when cpu_hlt=1.
  - HALT is exited only by reset.
- Grant rule (combinational):
  - host_gnt = host_req & (!cpu_req | starve_cnt==STARVE_MAX | mode==HALT | cpu_hlt).
  - cpu_stall = cpu_req & host_gnt.
- Memory mux: the winner's re/we/addr/wdata drive mem_*. Exactly one access per cycle.
- Starvation counter:
  - Increments each cycle host_req&!host_gnt, saturating at STARVE_MAX.
  - Cleared on host_gnt or !host_req.
  - After a forced host grant, the counter is 0, so the stalled CPU wins the next cycle. The CPU is therefore never stalled two cycles in a row in NORM.
- Read return:
  - host_rvalid is registered as host_gnt&!host_we, and is high exactly one cycle after a host read grant.
  - host_rdata = mem_rdata; cpu_rdata = mem_rdata.
  - The pipeline samples cpu_rdata only in the cycle after its unstalled load.
- Simultaneous events:
  - CPU and host request together with the counter below max: CPU served, counter+1.
  - Host write and CPU load to the same address in the same cycle: only one is performed; ordering follows grant order.
- Reset mid-operation: a pending host_rvalid is dropped, the counter clears, and the mode returns to NORM.

Optional Feature:
- Macro: DM_ARB_STATS_EN.
- When defined, the block adds:
  - 16-bit saturating counters stat_host_gnts and stat_cpu_stalls (outputs, reset 0).
  - stat_clr input, which synchronously zeroes both counters; stat_clr has priority over increment in the same cycle.
- When undefined, these ports and flops do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package/include: mode encodings MODE_NORM=1'b0 and MODE_HALT=1'b1, default STARVE_MAX, and the ADDR_W/DATA_W defaults alongside the existing common params.
- One natural sub-module, dm_arb_starve_cnt: the saturating counter with clear, parameterised by STARVE_MAX, returning the at-max flag.

Test Plan:
- Host read alone: host_req=1, addr=0x0010, mem holds 0xBEEF -> host_gnt=1 same cycle, host_rvalid=1 and host_rdata=0xBEEF next cycle, cpu_stall=0.
- Contention: cpu_re every cycle plus host write to 0x0020 of 0x1234, STARVE_MAX=4 -> CPU served for 4 cycles, host_gnt and cpu_stall in the 5th, CPU served in the 6th, mem[0x20]=0x1234.
- Priority: CPU store to 0x0030 of 0x5555 concurrent with a host read of 0x0030, counter 0 -> store first; host read granted when the CPU idles and returns 0x5555.
- Halt: cpu_hlt=1 while host_req is held and cpu_re=1 -> every cycle host_gnt=1 and cpu_stall=1; the mode stays HALT after cpu_hlt drops.
- Reset mid-read: assert rst_n=0 in the cycle after a host read grant -> host_rvalid=0 immediately, counter=0, mode=NORM.
- With DM_ARB_STATS_EN: 3 forced grants -> stat_host_gnts=3, stat_cpu_stalls=3; stat_clr -> both 0 next cycle.
